// File: rtl/trail_compositor.sv
// Light-cycle trail compositor: frame buffer, sprite overlay, per-bike collision
// probes and the IDLE/RUN/OVER round state machine.
module trail_compositor #(
  parameter int         N_PLAYERS    = 2,
  parameter int         H_RES        = 640,
  parameter int         V_RES        = 480,
  parameter logic [3:0] BG_ENUM      = 4'h8,
  parameter logic [3:0] BLOCK_ENUM   = 4'h7,
  parameter logic [3:0] SPRITE_CLEAR = 4'hF
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   frame_clk,
  input  logic [9:0]             DrawX,
  input  logic [9:0]             DrawY,
  input  logic                   WE,
  input  logic [18:0]            write_address,
  input  logic [15:0]            Data_In,
  input  logic [3:0]             Sprite_In,
  input  logic [10*N_PLAYERS-1:0] Head_X,
  input  logic [10*N_PLAYERS-1:0] Head_Y,
  input  logic [2*N_PLAYERS-1:0]  Head_dir,
  input  logic                   clear_over,
  output logic [3:0]             color_enum,
  output logic [N_PLAYERS-1:0]   crash,
  output logic                   crash_valid,
  output logic                   game_over
);

  localparam int DEPTH = H_RES * V_RES / 2;
  localparam int AW    = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, OVER} state_t;

  state_t state, state_nxt;

  // Frame buffer: two 4-bit pixels per word, pixel x even in [3:0], odd in [11:8]
  logic [15:0]   mem [DEPTH];
  logic [15:0]   rd_word;
  logic [AW-1:0] rd_addr;
  logic          wr_ok;
  logic          rd_unused;

  assign rd_addr   = AW'(DrawX[9:1]) + AW'(DrawY) * AW'(H_RES / 2);
  assign wr_ok     = write_address < 19'(DEPTH);
  assign rd_unused = ^{rd_word[15:12], rd_word[7:4]};

  // NOTE: the frame buffer has no reset so it maps onto block RAM; reading the
  // array before the write lands gives old data on a same-address collision.
  always_ff @(posedge Clk) begin
    if (WE && wr_ok) mem[write_address[AW-1:0]] <= Data_In;
    rd_word <= mem[rd_addr];
  end

  // Stage 1: coordinate, parity and sprite aligned with the RAM output
  logic [9:0] x1, y1;
  logic       par1;
  logic [3:0] spr1;
  logic [3:0] pixel;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      x1   <= '0;
      y1   <= '0;
      par1 <= 1'b0;
      spr1 <= '0;
    end else begin
      x1   <= DrawX;
      y1   <= DrawY;
      par1 <= DrawX[0];
      spr1 <= Sprite_In;
    end
  end

  assign pixel = par1 ? rd_word[11:8] : rd_word[3:0];

  // Stage 2: final colour
  always_ff @(posedge Clk) begin
    if (Reset)                      color_enum <= '0;
    else if (state == OVER)         color_enum <= BLOCK_ENUM;
    else if (spr1 != SPRITE_CLEAR)  color_enum <= spr1;
    else                            color_enum <= pixel;
  end

  // Probe point sits just ahead of each head; arithmetic wraps modulo 1024
  logic [9:0]           probe_x [N_PLAYERS];
  logic [9:0]           probe_y [N_PLAYERS];
  logic [N_PLAYERS-1:0] hit_now;

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    for (int i = 0; i < N_PLAYERS; i++) begin
      probe_x[i] = Head_X[10*i +: 10] + 10'd3;
      probe_y[i] = Head_Y[10*i +: 10] + 10'd3;
      case (Head_dir[2*i +: 2])
        2'b00:   probe_y[i] = Head_Y[10*i +: 10] + 10'd16;
        2'b01:   probe_y[i] = Head_Y[10*i +: 10] - 10'd16;
        2'b10:   probe_x[i] = Head_X[10*i +: 10] + 10'd16;
        default: probe_x[i] = Head_X[10*i +: 10] - 10'd16;
      endcase
    end
  end

  always_comb begin
    hit_now = '0;
    for (int i = 0; i < N_PLAYERS; i++)
      hit_now[i] = (x1 == probe_x[i]) && (y1 == probe_y[i]) && (pixel != BG_ENUM);
  end

  // Round FSM
  logic frame_prev;
  logic frame_edge;
  logic frame_commit;
  logic accumulate;
  logic [N_PLAYERS-1:0] hit;

  assign frame_edge = frame_clk & ~frame_prev;

  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (frame_edge)          state_nxt = RUN;
      RUN:     if (frame_edge && |hit)  state_nxt = OVER;
      OVER:    if (clear_over)          state_nxt = IDLE;
      default:                          state_nxt = IDLE;
    endcase
  end

  always_comb begin
    game_over    = (state == OVER);
    accumulate   = (state == RUN);
    frame_commit = (state == RUN) && frame_edge;
  end

  // A hit seen on the edge cycle seeds the new frame instead of the old one
  always_ff @(posedge Clk) begin
    if (Reset) begin
      frame_prev  <= 1'b0;
      hit         <= '0;
      crash       <= '0;
      crash_valid <= 1'b0;
    end else begin
      frame_prev  <= frame_clk;
      crash_valid <= frame_commit;
      if (frame_commit) crash <= hit;
      if (!accumulate)       hit <= '0;
      else if (frame_commit) hit <= hit_now;
      else                   hit <= hit | hit_now;
    end
  end

endmodule

// File: tb/tb_trail_compositor.sv
// Directed bench for trail_compositor: pixel pipeline table plus hand-written
// frame/collision sequences on a reduced 128x128 raster.
module tb_trail_compositor;

  localparam int H = 128;
  localparam int V = 128;

  logic        Clk, Reset, frame_clk, WE, clear_over;
  logic [9:0]  DrawX, DrawY;
  logic [18:0] write_address;
  logic [15:0] Data_In;
  logic [3:0]  Sprite_In;
  logic [19:0] Head_X, Head_Y;
  logic [3:0]  Head_dir;
  logic [3:0]  color_enum;
  logic [1:0]  crash;
  logic        crash_valid, game_over;

  trail_compositor #(.N_PLAYERS(2), .H_RES(H), .V_RES(V)) dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk),
    .DrawX(DrawX), .DrawY(DrawY),
    .WE(WE), .write_address(write_address), .Data_In(Data_In),
    .Sprite_In(Sprite_In),
    .Head_X(Head_X), .Head_Y(Head_Y), .Head_dir(Head_dir),
    .clear_over(clear_over),
    .color_enum(color_enum), .crash(crash),
    .crash_valid(crash_valid), .game_over(game_over)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [9:0] x;
    logic [9:0] y;
    logic [3:0] spr;
    logic [3:0] exp;
  } pix_vec_t;

  pix_vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic put(input logic [9:0] x, input logic [9:0] y);
    DrawX = x;
    DrawY = y;
  endtask

  task automatic wr(input int addr, input logic [15:0] d);
    WE = 1'b1;
    write_address = 19'(addr);
    Data_In = d;
    tick();
    WE = 1'b0;
  endtask

  task automatic frame_pulse();
    frame_clk = 1'b1;
    tick();
    frame_clk = 1'b0;
  endtask

  // Present the P0 probe pixel for one cycle, then park on a background pixel
  task automatic inject_p0_hit();
    put(10'd116, 10'd103);
    tick();
    put(10'd10, 10'd10);
    tick();
    tick();
  endtask

  initial begin
    Reset = 1'b1; frame_clk = 1'b0; WE = 1'b0; clear_over = 1'b0;
    write_address = '0; Data_In = '0; Sprite_In = 4'hF;
    DrawX = 10'd10; DrawY = 10'd10;
    Head_X = {10'd20, 10'd100};
    Head_Y = {10'd20, 10'd100};
    Head_dir = {2'b00, 2'b00};
    tick(); tick(); tick();
    check("rst_color", 32'(color_enum), 32'h0);
    check("rst_crash", 32'(crash), 32'h0);
    check("rst_valid", 32'(crash_valid), 32'h0);
    check("rst_over", 32'(game_over), 32'h0);
    Reset = 1'b0;

    for (int a = 0; a < H * V / 2; a++) wr(a, 16'h0808);
    wr(0, 16'h0A05);      // (0,0)=5 (1,0)=A
    wr(65, 16'h0C0B);     // (2,1)=B (3,1)=C
    wr(8191, 16'h0D08);   // (127,127)=D, last word
    wr(6650, 16'h0802);   // (116,103)=2, P0 probe when heading right
    wr(26, 16'h0208);     // (53,0)=2
    wr(1370, 16'h0208);   // (53,21)=2

    vecs[0] = '{x: 10'd5,   y: 10'd2,   spr: 4'hF, exp: 4'h8};
    vecs[1] = '{x: 10'd5,   y: 10'd2,   spr: 4'h3, exp: 4'h3};
    vecs[2] = '{x: 10'd0,   y: 10'd0,   spr: 4'hF, exp: 4'h5};
    vecs[3] = '{x: 10'd1,   y: 10'd0,   spr: 4'hF, exp: 4'hA};
    vecs[4] = '{x: 10'd2,   y: 10'd1,   spr: 4'hF, exp: 4'hB};
    vecs[5] = '{x: 10'd3,   y: 10'd1,   spr: 4'hF, exp: 4'hC};
    vecs[6] = '{x: 10'd3,   y: 10'd1,   spr: 4'h1, exp: 4'h1};
    vecs[7] = '{x: 10'd127, y: 10'd127, spr: 4'hF, exp: 4'hD};

    // Streamed back-to-back: each colour must appear exactly two cycles later
    for (int i = 0; i < 9; i++) begin
      if (i < 8) begin
        put(vecs[i].x, vecs[i].y);
        Sprite_In = vecs[i].spr;
      end
      tick();
      if (i >= 1) check($sformatf("pix_vec%0d", i - 1), 32'(color_enum), 32'(vecs[i - 1].exp));
    end
    Sprite_In = 4'hF;

    // Same-address write and read: old word first, new word one cycle later
    put(10'd4, 10'd2);
    WE = 1'b1; write_address = 19'd130; Data_In = 16'h0809;
    tick();
    WE = 1'b0;
    tick();
    check("rdw_old", 32'(color_enum), 32'h8);
    tick();
    check("rdw_new", 32'(color_enum), 32'h9);
    wr(130, 16'h0808);

    // Upward probe wraps to Y=1013, so neither Y=0 nor Y=21 may hit
    put(10'd10, 10'd10);
    frame_pulse();
    check("idle_run_valid", 32'(crash_valid), 32'h0);
    check("idle_run_over", 32'(game_over), 32'h0);
    Head_X = {10'd50, 10'd100};
    Head_Y = {10'd5, 10'd100};
    Head_dir = {2'b01, 2'b00};
    put(10'd53, 10'd0);  tick();
    put(10'd53, 10'd21); tick();
    put(10'd10, 10'd10); tick(); tick();
    frame_pulse();
    check("wrap_valid", 32'(crash_valid), 32'h1);
    check("wrap_crash", 32'(crash), 32'h0);
    check("wrap_over", 32'(game_over), 32'h0);
    tick();
    check("wrap_valid_1cyc", 32'(crash_valid), 32'h0);

    // Hit landing on the frame-edge cycle belongs to the next frame
    Head_dir = {2'b01, 2'b10};
    put(10'd116, 10'd103);
    tick();
    put(10'd10, 10'd10);
    frame_clk = 1'b1;
    tick();
    frame_clk = 1'b0;
    check("edge_hit_crash", 32'(crash), 32'h0);
    check("edge_hit_valid", 32'(crash_valid), 32'h1);
    check("edge_hit_over", 32'(game_over), 32'h0);
    tick(); tick(); tick();
    frame_pulse();
    check("late_hit_crash", 32'(crash), 32'h1);
    check("late_hit_valid", 32'(crash_valid), 32'h1);
    check("late_hit_over", 32'(game_over), 32'h1);
    tick();
    check("late_hit_color", 32'(color_enum), 32'h7);

    // clear_over together with a frame edge: straight to IDLE, no pulse
    clear_over = 1'b1;
    frame_clk = 1'b1;
    tick();
    check("clear_edge_over", 32'(game_over), 32'h0);
    check("clear_edge_valid", 32'(crash_valid), 32'h0);
    clear_over = 1'b0;
    frame_clk = 1'b0;
    tick();
    check("clear_edge_valid2", 32'(crash_valid), 32'h0);
    tick();
    check("clear_color", 32'(color_enum), 32'h8);

    // Plain P0 crash heading right, sprite cannot override the block fill
    frame_pulse();
    inject_p0_hit();
    frame_pulse();
    check("p0_crash", 32'(crash), 32'h1);
    check("p0_valid", 32'(crash_valid), 32'h1);
    check("p0_over", 32'(game_over), 32'h1);
    Sprite_In = 4'h3;
    tick();
    check("p0_valid_1cyc", 32'(crash_valid), 32'h0);
    tick();
    check("p0_block_color", 32'(color_enum), 32'h7);
    Sprite_In = 4'hF;

    // Reset mid-frame discards the pending hit
    clear_over = 1'b1;
    tick();
    clear_over = 1'b0;
    check("back_idle", 32'(game_over), 32'h0);
    frame_pulse();
    inject_p0_hit();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check("mid_rst_crash", 32'(crash), 32'h0);
    check("mid_rst_over", 32'(game_over), 32'h0);
    check("mid_rst_valid", 32'(crash_valid), 32'h0);
    tick(); tick();
    frame_pulse();
    check("mid_rst_edge1", 32'(crash_valid), 32'h0);
    tick();
    check("mid_rst_edge1b", 32'(crash_valid), 32'h0);
    tick(); tick();
    frame_pulse();
    check("mid_rst_edge2_valid", 32'(crash_valid), 32'h1);
    check("mid_rst_edge2_crash", 32'(crash), 32'h0);
    check("mid_rst_edge2_over", 32'(game_over), 32'h0);

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/trail_compositor.md
TRAIL_COMPOSITOR -- requirements
Module: trail_compositor

Interface
REQ-001 SHALL provide parameter N_PLAYERS, default 2, number of bikes (range 1..4).
REQ-002 SHALL provide parameter H_RES, default 640, and V_RES, default 480, the visible raster size.
REQ-003 SHALL provide parameter BG_ENUM, default 4'h8, the trail-free background pixel.
REQ-004 SHALL provide parameter BLOCK_ENUM, default 4'h7, the game-over fill colour.
REQ-005 SHALL provide parameter SPRITE_CLEAR, default 4'hF, the transparent sprite code.
REQ-006 Clk  in  1  system clock; one clock, reset is synchronous and active-high.
REQ-007 Reset  in  1  synchronous active-high reset.
REQ-008 frame_clk  in  1  frame strobe (~60 Hz), sampled on Clk; a rising edge marks a new frame.
REQ-009 DrawX, DrawY  in  10 each  current raster coordinate.
REQ-010 WE, write_address, Data_In  in  1/19/16  frame-buffer write port: word address and two packed pixels.
REQ-011 Sprite_In  in  4  bike sprite colour for the current pixel.
REQ-012 Head_X, Head_Y  in  10*N_PLAYERS each  packed head positions; player i is in bits [10i+9:10i].
REQ-013 Head_dir  in  2*N_PLAYERS  packed directions: 00 down, 01 up, 10 right, 11 left.
REQ-014 clear_over  in  1  acknowledges game over and restarts the round.
REQ-015 color_enum  out  4  final pixel colour enum.
REQ-016 crash  out  N_PLAYERS  per-player collision vector for the last frame.
REQ-017 crash_valid  out  1  single-cycle pulse when crash updates.
REQ-018 game_over  out  1  sticky collision indicator.

Function
REQ-019 SHALL contain a frame buffer of H_RES*V_RES/2 16-bit words with 1-cycle synchronous read; on write/read to the same address, the read SHALL return the old data.
REQ-020 Read address SHALL be DrawX/2 + DrawY*(H_RES/2); pixel = word[3:0] for even DrawX and word[11:8] for odd DrawX.
REQ-021 The pixel path SHALL be a 2-stage pipeline: color_enum reflects the DrawX/DrawY presented 2 cycles earlier; DrawX parity and Sprite_In SHALL be delayed to match.
REQ-022 color_enum SHALL be BLOCK_ENUM if state is OVER; else Sprite_In when Sprite_In != SPRITE_CLEAR; else the frame-buffer pixel.
REQ-023 Probe point per player SHALL be the head position plus an offset, modulo 1024: 00 -> (+3,+16), 01 -> (+3,-16), 10 -> (+16,+3), 11 -> (-16,+3).
REQ-024 A hit SHALL set hit[i] when the delayed coordinate equals probe i and the frame-buffer pixel != BG_ENUM; hits accumulate until the frame edge.
REQ-025 FSM states: IDLE (after reset, waits for the first frame edge) -> RUN; RUN -> OVER on a frame edge with any hit bit set; OVER -> IDLE on clear_over.
REQ-026 On each frame edge in RUN, crash <= hit, crash_valid = 1 for exactly one cycle, and hit is cleared.
REQ-027 A hit in the same cycle as the frame edge SHALL count toward the new frame.
REQ-028 game_over SHALL be 1 exactly while the state is OVER.
REQ-029 In IDLE and OVER, hit accumulation SHALL be suppressed.
REQ-030 If clear_over and a frame edge coincide, the FSM SHALL go to IDLE and no crash_valid SHALL be issued.
REQ-031 Frame-buffer writes SHALL be accepted in every state.

Reset
REQ-032 Reset SHALL drive state to IDLE, crash = 0, crash_valid = 0, game_over = 0, hit = 0, pipeline registers = 0, color_enum = 0, and the frame-edge detector = 0.
REQ-033 Frame-buffer contents SHALL be unaffected by Reset.
REQ-034 Reset asserted mid-frame SHALL discard accumulated hits; the next crash_valid SHALL come only after IDLE -> RUN and one further frame edge.

Verification
REQ-035 Write 16'h0808 to every word, DrawX=5, DrawY=2 -> color_enum = 4'h8 2 cycles later; Sprite_In=4'h3 -> 4'h3.
REQ-036 P0 head (100,100), dir 10, pixel (116,103) = 4'h2 -> at the next frame edge: crash = 2'b01, crash_valid 1 cycle, game_over = 1, color_enum = 4'h7.
REQ-037 P1 dir 01, head Y=5: probe Y wraps to 1013, no hit at Y=5-16 on screen -> crash = 0 after the frame edge.
REQ-038 Hit injected on the frame-edge cycle -> crash = 0 this frame, and the bit appears at the next edge.
REQ-039 In OVER, clear_over coincident with a frame edge -> IDLE, crash_valid stays 0, game_over = 0.
REQ-040 Reset pulsed mid-frame after a hit -> crash_valid = 0 until two frame edges have passed.
